dbus_mux_n: RTL and testbench

DBUS_MUX_N -- requirements
Module: dbus_mux_n

---
 rtl/dbus_mux_n.sv | 198 +++++++++++++++++++
 tb/tb_dbus_mux_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_mux_n.sv
// dbus_mux_n: core data-bus demultiplexer onto NUM_SLV address windows.
// Writes complete in the same cycle. Reads wait in RD_WAIT for the selected
// slave's ready flag and return through a one-cycle RESP.
// Optional feature macro: DBUS_TIMEOUT_EN adds a read-wait timeout that
// returns 0xDEADBEEF and raises an error event.
module dbus_mux_n #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_LEN = 16,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned NUM_SLV  = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic [ADDR_LEN-1:0]         addr,
    input  logic                        rd_req,
    input  logic                        wr_req,
    input  logic [XLEN/8-1:0]           wr_be,
    input  logic [XLEN-1:0]             wr_data,
    output logic                        rd_ready,
    output logic                        wr_ready,
    output logic [XLEN-1:0]             rd_data,
    output logic [ADDR_LEN-SEL_W-1:0]   slv_addr,
    output logic [NUM_SLV-1:0]          slv_wr_en,
    output logic [NUM_SLV-1:0]          slv_rd_en,
    output logic [XLEN/8-1:0]           slv_be,
    output logic [XLEN-1:0]             slv_wr_data,
    input  logic [NUM_SLV*XLEN-1:0]     slv_rd_data,
    input  logic [NUM_SLV-1:0]          slv_rd_ready,
    input  logic                        err_clr,
    output logic                        err_flag,
    output logic [7:0]                  err_cnt
);

    localparam int unsigned OFF_W = ADDR_LEN - SEL_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    // Elaboration-time guard against illegal parameter combinations
    if ((XLEN != 32 && XLEN != 64) || NUM_SLV < 2 || NUM_SLV > (1 << SEL_W) ||
        TIMEOUT < 1 || TIMEOUT > 65535 || SEL_W >= ADDR_LEN) begin : g_bad_param
        $error("dbus_mux_n: illegal parameter combination");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  r_idx;
    logic              w_mapped;
    logic [XLEN-1:0]   w_sel_data;
    logic              w_sel_rdy;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_rd_unmap;
    logic              w_rd_cap;
    logic              w_rd_tmo;
    logic              w_tmo;
    logic              w_err_evt;

    assign w_idx       = addr[ADDR_LEN-1 -: SEL_W];
    assign w_mapped    = {1'b0, w_idx} < (SEL_W+1)'(NUM_SLV);
    assign slv_addr    = addr[OFF_W-1:0];
    assign slv_be      = wr_be;
    assign slv_wr_data = wr_data;
    assign rd_ready    = (r_state == S_RESP);

    // Select data and ready flag of the slave latched at read acceptance
    always_comb begin
        w_sel_data = '0;
        w_sel_rdy  = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == SEL_W'(i)) begin
                w_sel_data = slv_rd_data[i*XLEN +: XLEN];
                w_sel_rdy  = slv_rd_ready[i];
            end
        end
    end

`ifdef DBUS_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    assign w_tmo = ((r_tmo_cnt + 16'd1) == 16'(TIMEOUT));

    // Read-wait cycle counter, restarted whenever a read enters RD_WAIT
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_rd_fire) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == S_RD_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and same-cycle handshake/strobe outputs
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        slv_wr_en   = '0;
        slv_rd_en   = '0;
        w_wr_fire   = 1'b0;
        w_rd_fire   = 1'b0;
        w_rd_unmap  = 1'b0;
        w_rd_cap    = 1'b0;
        w_rd_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_req) begin
                    w_wr_fire = 1'b1;
                end else if (rd_req) begin
                    if (w_mapped) begin
                        w_rd_fire   = 1'b1;
                        w_state_nxt = S_RD_WAIT;
                    end else begin
                        w_rd_unmap  = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RD_WAIT: begin
                if (w_sel_rdy) begin
                    w_rd_cap    = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_tmo) begin
                    w_rd_tmo    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Strobes are gated by reset so they stay quiet while rstb is low
        wr_ready = rstb & w_wr_fire;
        for (int i = 0; i < NUM_SLV; i++) begin
            slv_wr_en[i] = rstb & w_wr_fire & w_mapped & (w_idx == SEL_W'(i));
            slv_rd_en[i] = rstb & w_rd_fire & (w_idx == SEL_W'(i));
        end
    end

    // Latch the slave index of an accepted read
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_idx <= '0;
        end else if (w_rd_fire) begin
            r_idx <= w_idx;
        end
    end

    // Read return data: zero for unmapped, slave data, or timeout pattern
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_data <= '0;
        end else if (w_rd_unmap) begin
            rd_data <= '0;
        end else if (w_rd_cap) begin
            rd_data <= w_sel_data;
        end else if (w_rd_tmo) begin
            rd_data <= {XLEN/32{32'hDEADBEEF}};
        end
    end

    assign w_err_evt = (w_wr_fire & ~w_mapped) | w_rd_unmap | w_rd_tmo;

    // Sticky error flag and saturating error counter; clear wins
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_flag <= 1'b0;
            err_cnt  <= 8'd0;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= 8'd0;
        end else if (w_err_evt) begin
            err_flag <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_mux_n.sv
// Self-checking bench for dbus_mux_n: directed scenarios plus randomized
// read/write traffic against a transaction-level reference model.
module tb_dbus_mux_n;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_LEN = 16;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned NUM_SLV  = 4;
    localparam int unsigned TIMEOUT  = 10;

    logic                      clk;
    logic                      rstb;
    logic [ADDR_LEN-1:0]       addr;
    logic                      rd_req;
    logic                      wr_req;
    logic [XLEN/8-1:0]         wr_be;
    logic [XLEN-1:0]           wr_data;
    logic                      rd_ready;
    logic                      wr_ready;
    logic [XLEN-1:0]           rd_data;
    logic [ADDR_LEN-SEL_W-1:0] slv_addr;
    logic [NUM_SLV-1:0]        slv_wr_en;
    logic [NUM_SLV-1:0]        slv_rd_en;
    logic [XLEN/8-1:0]         slv_be;
    logic [XLEN-1:0]           slv_wr_data;
    logic [NUM_SLV*XLEN-1:0]   slv_rd_data;
    logic [NUM_SLV-1:0]        slv_rd_ready;
    logic                      err_clr;
    logic                      err_flag;
    logic [7:0]                err_cnt;

    dbus_mux_n #(
        .XLEN(XLEN), .ADDR_LEN(ADDR_LEN), .SEL_W(SEL_W),
        .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rstb(rstb), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_be(wr_be), .wr_data(wr_data), .rd_ready(rd_ready), .wr_ready(wr_ready),
        .rd_data(rd_data), .slv_addr(slv_addr), .slv_wr_en(slv_wr_en),
        .slv_rd_en(slv_rd_en), .slv_be(slv_be), .slv_wr_data(slv_wr_data),
        .slv_rd_data(slv_rd_data), .slv_rd_ready(slv_rd_ready), .err_clr(err_clr),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Reference model state
    int unsigned    m_err_cnt  = 0;
    logic           m_err_flag = 1'b0;
    logic [XLEN-1:0] m_rd_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_error_event();
        m_err_flag = 1'b1;
        if (m_err_cnt < 255) m_err_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] idx);
        if (int'(idx) < NUM_SLV) return NUM_SLV'(1) << idx;
        return '0;
    endfunction

    task automatic check_err(input string tag);
        check({tag, "_flag"}, err_flag, m_err_flag);
        check({tag, "_cnt"}, err_cnt, m_err_cnt);
    endtask

    task automatic noise(input logic [SEL_W-1:0] idx);
        for (int i = 0; i < NUM_SLV; i++) slv_rd_data[i*XLEN +: XLEN] = $urandom();
        slv_rd_ready = NUM_SLV'($urandom()) & ~onehot(idx);
    endtask

    // One write cycle in IDLE; checks same-cycle strobes and error accounting
    task automatic do_write(input logic [ADDR_LEN-1:0] a, input logic [XLEN/8-1:0] be,
                            input logic [XLEN-1:0] d);
        logic [SEL_W-1:0] idx;
        idx = a[ADDR_LEN-1 -: SEL_W];
        addr = a; wr_be = be; wr_data = d; wr_req = 1'b1;
        #1;
        check("wr_ready", wr_ready, 1'b1);
        check("slv_wr_en", slv_wr_en, onehot(idx));
        check("slv_rd_en_wr", slv_rd_en, '0);
        check("slv_be", slv_be, be);
        check("slv_wr_data", slv_wr_data, d);
        check("slv_addr", slv_addr, a[ADDR_LEN-SEL_W-1:0]);
        if (int'(idx) >= NUM_SLV) m_error_event();
        tick();
        wr_req = 1'b0;
        check_err("wr_err");
    endtask

    // Full read transaction, optionally sharing its first cycle with a write
    task automatic do_read(input logic [ADDR_LEN-1:0] a, input int dly, input bit with_wr,
                           input logic [XLEN/8-1:0] be, input logic [XLEN-1:0] wd);
        logic [SEL_W-1:0] idx;
        int ii;
        idx = a[ADDR_LEN-1 -: SEL_W];
        ii  = int'(idx);
        addr = a; rd_req = 1'b1;
        if (with_wr) begin
            wr_req = 1'b1; wr_be = be; wr_data = wd;
            #1;
            check("both_wr_ready", wr_ready, 1'b1);
            check("both_slv_wr_en", slv_wr_en, onehot(idx));
            check("both_slv_be", slv_be, be);
            check("both_no_rd_en", slv_rd_en, '0);
            if (ii >= NUM_SLV) m_error_event();
            tick();
            wr_req = 1'b0;
        end
        #1;
        check("rd_en", slv_rd_en, onehot(idx));
        check("rd_no_wr_ready", wr_ready, 1'b0);
        if (ii >= NUM_SLV) begin
            m_error_event();
            m_rd_data = '0;
            tick();
        end else begin
            tick();
            check("rd_en_pulse", slv_rd_en, '0);
            for (int c = 0; c < dly; c++) begin
                noise(idx);
                #1;
                check("wait_rd_ready", rd_ready, 1'b0);
                check("wait_en", {slv_rd_en, slv_wr_en}, '0);
                tick();
            end
            noise(idx);
            slv_rd_ready = slv_rd_ready | onehot(idx);
            m_rd_data = slv_rd_data[ii*XLEN +: XLEN];
            tick();
            slv_rd_ready = '0;
        end
        check("rd_ready", rd_ready, 1'b1);
        check("rd_data", rd_data, m_rd_data);
        check("resp_en", {slv_rd_en, slv_wr_en, wr_ready}, '0);
        check_err("rd_err");
        rd_req = 1'b0;
        tick();
        check("rd_ready_drop", rd_ready, 1'b0);
        check("rd_data_hold", rd_data, m_rd_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb = 1'b0; addr = 16'h4000; rd_req = 1'b1; wr_req = 1'b1;
        wr_be = '1; wr_data = '0; err_clr = 1'b0;
        slv_rd_data = '0; slv_rd_ready = '1;
        #3;
        // Outputs held at reset values even with requests pending
        check("rst_rd_ready", rd_ready, 1'b0);
        check("rst_rd_data", rd_data, '0);
        check("rst_en", {slv_rd_en, slv_wr_en}, '0);
        check_err("rst_err");
        rd_req = 1'b0; wr_req = 1'b0; slv_rd_ready = '0;
        tick();
        tick();
        rstb = 1'b1;
        tick();

        // Unmapped read at index 5
        do_read(16'hA000, 0, 1'b0, '0, '0);
        // Slave 1 read with ready after a short wait
        do_read(16'h2004, 2, 1'b0, '0, '0);
        // Simultaneous write and read at slave 0
        do_read(16'h0000, 1, 1'b1, 4'b0010, 32'hCAFEF00D);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [ADDR_LEN-1:0] a;
            int op;
            a  = ADDR_LEN'($urandom());
            op = $urandom_range(0, 2);
            if (op == 0) do_write(a, 4'($urandom()), $urandom());
            else do_read(a, $urandom_range(0, 4), op == 2, 4'($urandom()), $urandom());
        end

        // Saturation with back-to-back unmapped writes
        for (int t = 0; t < 300; t++) begin
            do_write({3'($urandom_range(4, 7)), 13'($urandom())}, '1, $urandom());
        end
        check("sat_cnt", err_cnt, 8'd255);
        // Clear takes priority over a coincident error event
        err_clr = 1'b1; addr = 16'hE000; wr_req = 1'b1;
        tick();
        err_clr = 1'b0; wr_req = 1'b0;
        m_err_cnt = 0; m_err_flag = 1'b0;
        check_err("clr");

`ifdef DBUS_TIMEOUT_EN
        // Slave 3 never answers; timeout response after TIMEOUT wait cycles
        addr = 16'h6000; rd_req = 1'b1;
        #1;
        check("tmo_rd_en", slv_rd_en, 4'b1000);
        tick();
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            noise(3'd3);
            #1;
            check("tmo_wait", rd_ready, 1'b0);
            tick();
        end
        slv_rd_ready = '0;
        m_error_event();
        m_rd_data = 32'hDEADBEEF;
        check("tmo_rd_ready", rd_ready, 1'b1);
        check("tmo_rd_data", rd_data, m_rd_data);
        check_err("tmo_err");
        rd_req = 1'b0;
        tick();
`endif

        // Make error state nonzero so the reset check below is meaningful
        do_write(16'hC000, '1, 32'h1);

        // Reset during RD_WAIT aborts the read
        addr = 16'h4000; rd_req = 1'b1;
        tick();
        rstb = 1'b0;
        wr_req = 1'b1;
        #1;
        check("abort_rd_ready", rd_ready, 1'b0);
        check("abort_rd_data", rd_data, '0);
        check("abort_en", {slv_rd_en, slv_wr_en}, '0);
        m_err_cnt = 0; m_err_flag = 1'b0; m_rd_data = '0;
        check_err("abort_err");
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        rstb = 1'b1;
        slv_rd_ready = '1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_no_ready", rd_ready, 1'b0);
            check("abort_data", rd_data, '0);
        end
        slv_rd_ready = '0;
        // A write completing immediately shows the FSM is back in IDLE
        do_write(16'h0010, 4'b1111, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
